// File: rtl/rls_pkg.sv
// Shared types and constants for the reset/lock sequencer.
// State codes match the CUR register encoding.
package rls_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_WAIT   = 2'd2,
    S_NEXT   = 2'd3
  } state_t;

  localparam logic [2:0] A_START   = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_PULSE   = 3'd2;
  localparam logic [2:0] A_TIMEOUT = 3'd3;
  localparam logic [2:0] A_CTRL    = 3'd4;
  localparam logic [2:0] A_CUR     = 3'd5;

  localparam int CTRL_EN_DONE = 0;
  localparam int CTRL_EN_TO   = 1;
  localparam int CTRL_DONE    = 8;
  localparam int TO_LSB       = 16;

  localparam logic [31:0] PULSE_LEN_RST = 32'd16;
  localparam logic [31:0] TIMEOUT_RST   = 32'h0000_FFFF;

endpackage

// File: rtl/lock_debounce.sv
// Lock input synchroniser followed by a consecutive-high filter.
// locked rises only after STABLE_CYC unbroken high samples.
module lock_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lock_in,
  output logic locked
);

  localparam int SW = $clog2(STABLE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [SW-1:0]          stable;
  logic                   lock_s;

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      stable <= '0;
    end else begin
      sync <= SYNC_STAGES'({sync, lock_in});
      if (!lock_s)
        stable <= '0;
      else if (stable != SW'(STABLE_CYC))
        stable <= stable + SW'(1);
    end
  end

  assign locked = (stable == SW'(STABLE_CYC));

endmodule

// File: rtl/reset_lock_sequencer.sv
// Avalon-MM slave that pulses channel resets one at a time in index
// order and waits for each channel's debounced lock or a timeout.
module reset_lock_sequencer
  import rls_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int STABLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      avs_address,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  input  logic            avs_read,
  output logic [31:0]     avs_readdata,
  input  logic [N_CH-1:0] lock_in,
  output logic [N_CH-1:0] rst_out,
  output logic            busy,
  output logic            irq
);

  state_t state, state_d;

  logic [N_CH-1:0]  pending, rst_q, locked, to_sticky;
  logic [N_CH-1:0]  cur_oh, low_oh, clr_mask, set_mask, w1c_to;
  logic [4:0]       cur, low_idx;
  logic [CNT_W-1:0] pulse_len, timeout, cnt, wcnt, to_lat;
  logic             en_done, en_to, done_sticky;
  logic             go, to_wait, to_hit, fin, cur_locked;
  logic             wr_start, wr_status, wr_pulse, wr_to, wr_ctrl;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata};

  for (genvar i = 0; i < N_CH; i++) begin : g_db
    lock_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYC (STABLE_CYC)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .lock_in(lock_in[i]),
      .locked (locked[i])
    );
  end

  assign wr_start  = avs_write && (avs_address == A_START);
  assign wr_status = avs_write && (avs_address == A_STATUS);
  assign wr_pulse  = avs_write && (avs_address == A_PULSE);
  assign wr_to     = avs_write && (avs_address == A_TIMEOUT);
  assign wr_ctrl   = avs_write && (avs_address == A_CTRL);

  assign low_oh     = pending & (~pending + N_CH'(1));
  assign cur_locked = |(locked & cur_oh);

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pending[i]) low_idx = 5'(i);
  end

  always_comb begin
    state_d = state;
    go      = 1'b0;
    to_wait = 1'b0;
    to_hit  = 1'b0;
    fin     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|pending) begin
          state_d = S_ASSERT;
          go      = 1'b1;
        end
      end
      S_ASSERT: begin
        if (cnt <= CNT_W'(1)) begin
          state_d = S_WAIT;
          to_wait = 1'b1;
        end
      end
      S_WAIT: begin
        // Lock has priority over a timeout landing on the same cycle.
        if (cur_locked) begin
          state_d = S_NEXT;
        end else if (to_lat != '0 && wcnt == to_lat) begin
          state_d = S_NEXT;
          to_hit  = 1'b1;
        end
      end
      S_NEXT: begin
        if (|pending) begin
          state_d = S_ASSERT;
          go      = 1'b1;
        end else begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  assign clr_mask = go ? low_oh : '0;
  assign set_mask = wr_start ? avs_writedata[N_CH-1:0] : '0;
  assign w1c_to   = wr_status ? avs_writedata[TO_LSB +: N_CH] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      rst_q       <= '1;
      to_sticky   <= '0;
      done_sticky <= 1'b0;
      en_done     <= 1'b0;
      en_to       <= 1'b0;
      pulse_len   <= CNT_W'(PULSE_LEN_RST);
      timeout     <= CNT_W'(TIMEOUT_RST);
      cnt         <= '0;
      wcnt        <= '0;
      to_lat      <= '0;
      cur         <= '0;
      cur_oh      <= '0;
    end else begin
      if (wr_pulse) pulse_len <= avs_writedata[CNT_W-1:0];
      if (wr_to)    timeout   <= avs_writedata[CNT_W-1:0];
      if (wr_ctrl) begin
        en_done <= avs_writedata[CTRL_EN_DONE];
        en_to   <= avs_writedata[CTRL_EN_TO];
      end
      // A restart of the running channel must survive its own clear.
      pending <= (pending & ~clr_mask) | set_mask;
      if (go) begin
        cur    <= low_idx;
        cur_oh <= low_oh;
        rst_q  <= rst_q | low_oh;
        cnt    <= (pulse_len == '0) ? CNT_W'(1) : pulse_len;
      end else if (state == S_ASSERT && cnt > CNT_W'(1)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (to_wait) begin
        rst_q  <= rst_q & ~cur_oh;
        wcnt   <= CNT_W'(1);
        to_lat <= timeout;
      end else if (state == S_WAIT && wcnt != '1) begin
        wcnt <= wcnt + CNT_W'(1);
      end
      to_sticky   <= (to_sticky & ~w1c_to) | (to_hit ? cur_oh : '0);
      done_sticky <= (done_sticky &
                      ~(wr_ctrl & avs_writedata[CTRL_DONE])) | fin;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_STATUS: begin
        rd_mux[N_CH-1:0]        = locked;
        rd_mux[TO_LSB +: N_CH]  = to_sticky;
      end
      A_PULSE:   rd_mux = 32'(pulse_len);
      A_TIMEOUT: rd_mux = 32'(timeout);
      A_CTRL: begin
        rd_mux[CTRL_EN_DONE] = en_done;
        rd_mux[CTRL_EN_TO]   = en_to;
        rd_mux[CTRL_DONE]    = done_sticky;
      end
      A_CUR: begin
        rd_mux[4:0] = cur;
        rd_mux[9:8] = state;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs_readdata <= '0;
    else          avs_readdata <= avs_read ? rd_mux : '0;
  end

  assign rst_out = rst_q;
  assign busy    = (state != S_IDLE) || (|pending);
  assign irq     = (done_sticky & en_done) | ((|to_sticky) & en_to);

endmodule

// File: tb/tb_reset_lock_sequencer.sv
// Scenario bench for reset_lock_sequencer: expected values are queued
// as stimulus is applied and popped when the DUT output is sampled.
module tb_reset_lock_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [3:0]  lock_in;
  logic [3:0]  rst_out;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  reset_lock_sequencer #(
    .N_CH(4), .CNT_W(24), .STABLE_CYC(8), .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .lock_in      (lock_in),
    .rst_out      (rst_out),
    .busy         (busy),
    .irq          (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, want;
    logic [2:0]  a;
    reset_n = 1'b0;
    lock_in = '0;
    tick();
    tick();
    checks++;
    if ({busy, irq, rst_out} !== 6'b00_1111) begin
      errors++;
      $display("FAIL reset_outs got %b want 001111",
               {busy, irq, rst_out});
    end
    checks++;
    if (avs_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", avs_readdata);
    end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 3'd2 : (i == 1) ? 3'd3 : (i == 2) ? 3'd5 : 3'd7;
      exp_q.push_back((i == 0) ? 32'd16 :
                      (i == 1) ? 32'h0000_FFFF : 32'h0);
      rd(a, got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_read addr=%0d got %h want %h", a, got, want);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] got, want;
    wr(3'd2, 32'd10);
    wr(3'd4, 32'h1);
    wr(3'd0, 32'h1);
    for (int c = 1; c <= 33; c++) begin
      exp_q.push_back({27'b0, 1'(c < 32), (c <= 10) ? 4'hF : 4'hE});
      tick();
      want = exp_q.pop_front();
      got  = {27'b0, busy, rst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_seq c=%0d got %h want %h", c, got, want);
      end
      if (c == 20) lock_in[0] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back((i == 0) ? 32'h1 : (i == 1) ? 32'h101 : 32'h0);
      rd((i == 0) ? 3'd1 : (i == 1) ? 3'd4 : 3'd5, got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_read i=%0d got %h want %h", i, got, want);
      end
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL single_irq got %b want 1", irq);
    end
    wr(3'd4, 32'h100);
    exp_q.push_back(32'h0);
    rd(3'd4, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want || irq !== 1'b0) begin
      errors++;
      $display("FAIL done_w1c got %h irq %b want %h irq 0", got, irq, want);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] got, want;
    logic [3:0]  r;
    lock_in[0] = 1'b0;
    wr(3'd3, 32'd50);
    wr(3'd4, 32'h2);
    wr(3'd0, 32'hA);
    for (int c = 1; c <= 76; c++) begin
      r = (c <= 10) ? 4'hE : (c <= 71) ? 4'hC : 4'h4;
      exp_q.push_back({27'b0, 1'(c < 74), r});
      tick();
      want = exp_q.pop_front();
      got  = {27'b0, busy, rst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_seq c=%0d got %h want %h", c, got, want);
      end
      if (c == 5) lock_in[3] = 1'b1;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL timeout_irq got %b want 1", irq);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back((i == 0) ? 32'h0002_0008 :
                      (i == 1) ? 32'h0000_0003 : 32'h0000_0102);
      rd((i == 0) ? 3'd1 : (i == 1) ? 3'd5 : 3'd4, got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout_read i=%0d got %h want %h", i, got, want);
      end
    end
    wr(3'd1, 32'h0002_0000);
    exp_q.push_back(32'h0000_0008);
    rd(3'd1, got);
    want = exp_q.pop_front();
    checks++;
    if (got !== want || irq !== 1'b0) begin
      errors++;
      $display("FAIL to_w1c got %h irq %b want %h irq 0", got, irq, want);
    end
  endtask

  task automatic test_glitch();
    localparam int GLITCH_HI = 6;
    localparam int LOCK_EDGE = GLITCH_HI + 2 + 8;
    logic [31:0] got, want;
    wr(3'd2, 32'd4);
    wr(3'd3, 32'd0);
    lock_in[2] = 1'b1;
    wr(3'd0, 32'h4);
    for (int c = 1; c <= 20; c++) begin
      exp_q.push_back({27'b0, 1'(c < LOCK_EDGE + 2),
                       (c <= 4) ? 4'h4 : 4'h0});
      tick();
      want = exp_q.pop_front();
      got  = {27'b0, busy, rst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL glitch_seq c=%0d got %h want %h", c, got, want);
      end
      if (c == GLITCH_HI - 1) lock_in[2] = 1'b0;
      if (c == GLITCH_HI)     lock_in[2] = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, want;
    logic [3:0]  r;
    wr(3'd3, 32'd30);
    wr(3'd0, 32'h1);
    for (int c = 1; c <= 30; c++) begin
      r = (c <= 4) ? 4'h1 : (c >= 22 && c <= 25) ? 4'h4 : 4'h0;
      exp_q.push_back({27'b0, 1'(c < 28), r});
      tick();
      want = exp_q.pop_front();
      got  = {27'b0, busy, rst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_seq c=%0d got %h want %h", c, got, want);
      end
      if (c == 8) begin
        avs_address   = 3'd0;
        avs_writedata = 32'h4;
        avs_write     = 1'b1;
      end
      if (c == 9)  avs_write  = 1'b0;
      if (c == 10) lock_in[0] = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, want;
    wr(3'd2, 32'd20);
    wr(3'd0, 32'h3);
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if (busy !== 1'b1 || rst_out !== 4'h1) begin
      errors++;
      $display("FAIL mid_pre busy %b rst %h want busy 1 rst 1",
               busy, rst_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, irq, rst_out} !== 6'b00_1111) begin
      errors++;
      $display("FAIL mid_async got %b want 001111", {busy, irq, rst_out});
    end
    #2;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back((i == 0) ? 32'h0 : 32'd16);
      rd((i == 0) ? 3'd5 : 3'd2, got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_read i=%0d got %h busy %b want %h busy 0",
                 i, got, busy, want);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    lock_in       = '0;
    test_reset();
    test_single();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_lock_sequencer.md
Name: reset_lock_sequencer

Overview:
- Parametrised successor to the single-bit reset/lock PIO pairs used for the phi, theta, TDC and Nios-V domains.
- Sequences N_CH reset channels one at a time, in index order:
  - drives a programmable-width reset pulse on the channel;
  - waits for that channel's lock input to be stable high, with a programmable timeout;
  - records per-channel locked and timeout status.
- Sits on the soft-CPU Avalon-MM bus as a slave, between the CPU and the sensor clock/PLL domains.

Parameters:
- N_CH, 4, number of reset/lock channels (1..16).
- CNT_W, 24, width of pulse and timeout counters.
- STABLE_CYC, 8, consecutive synchronised-high lock cycles required to declare a channel locked.
- SYNC_STAGES, 2, synchroniser depth on lock_in.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  3  register word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- lock_in  in  N_CH  asynchronous lock indications from PLL/TDC domains.
- rst_out  out  N_CH  active-high reset to each channel.
- busy  out  1  high while any channel is pending or in progress.
- irq  out  1  level interrupt: OR of done_sticky and timeout_sticky, each gated by its IRQ_EN bit.

Behaviour:
- Reset values:
  - rst_out all ones: every domain is held in reset until sequenced.
  - busy=0, irq=0, avs_readdata=0.
  - PULSE_LEN=16, TIMEOUT=0xFFFF.
  - pending and all sticky bits cleared.
  - FSM in IDLE.
- Register map (word address):
  - 0 START (W): writing bit i sets pending[i]; it ORs into pending, including while busy.
  - 1 STATUS (R): [N_CH-1:0] live debounced locked; [N_CH+15:16] timeout_sticky per channel.
  - 1 STATUS (W1C): write ones to [N_CH+15:16] to clear timeout_sticky.
  - 2 PULSE_LEN (R/W): [CNT_W-1:0]. Value 0 is treated as 1.
  - 3 TIMEOUT (R/W): [CNT_W-1:0]. Value 0 means wait forever.
  - 4 CTRL (R/W): bit0 IRQ_EN_DONE, bit1 IRQ_EN_TO, bit8 done_sticky (W1C).
  - 5 CUR (R): [4:0] current channel index; [9:8] FSM state code.
  - Other addresses read 0; writes to them are ignored.
- FSM:
  - IDLE (code 0): if pending≠0, select the lowest set index → ASSERT. Load cnt=max(PULSE_LEN,1) and clear pending[idx] on the same edge.
  - ASSERT (code 1): rst_out[idx]=1; decrement cnt; at cnt==1 → WAIT.
  - WAIT (code 2):
    - rst_out[idx]=0 from the first WAIT cycle.
    - Count stable cycles of synchronised lock[idx]; any low sample resets the stable count.
    - stable==STABLE_CYC → NEXT with locked.
    - Elapsed WAIT cycles == TIMEOUT (TIMEOUT≠0) → NEXT with timeout_sticky[idx]=1.
    - If both fire on the same cycle, lock wins.
  - NEXT (code 3): single cycle.
    - pending≠0 → next lowest index via ASSERT.
    - Otherwise set done_sticky → IDLE.
- rst_out for channels not currently selected holds its last value: 1 until first sequenced, 0 afterwards. A channel never started stays in reset.
- Re-start of the channel currently in progress re-sets pending[idx]. The channel is sequenced again after the current pass.
- A PULSE_LEN or TIMEOUT write mid-sequence takes effect at the next ASSERT load or WAIT entry. It does not affect running counters.
- busy = (state≠IDLE) | (pending≠0).
- Locked status is the live STABLE_CYC-debounced lock value, continuously evaluated for all channels. A post-sequence lock loss is visible in STATUS; it does not re-trigger the sequence.
- Counters saturate and never wrap.
- Asserting reset_n mid-operation returns every output and register to its reset value immediately, including rst_out all ones.

Decomposition:
- Package rls_pkg holds:
  - FSM state enum (2-bit codes as in CUR);
  - register address constants;
  - CTRL bit positions;
  - reset defaults for PULSE_LEN and TIMEOUT.
- One sub-module: lock_debounce, instantiated N_CH times. It contains the SYNC_STAGES synchroniser plus the STABLE_CYC consecutive-high filter, and outputs a clean locked bit.

Test Plan:
- After reset, with lock_in=0: rst_out=4'b1111, busy=0, readback of PULSE_LEN=16 and TIMEOUT=0xFFFF.
- Write START=0x1, PULSE_LEN=10, and hold lock_in[0] high after 20 cycles:
  - rst_out[0] is high for exactly 10 cycles, then low;
  - STATUS[0]=1 once lock_in[0] has been high 8 stable cycles plus 2 sync cycles;
  - done_sticky=1.
- Write START=0xA with TIMEOUT=50, keeping lock_in[1] low and lock_in[3] lock after 5 cycles:
  - channel 1 is processed before channel 3;
  - timeout_sticky[1] is set after 50 WAIT cycles;
  - channel 3 ends locked;
  - STATUS=0x0002_0008.
- Glitch lock_in[2] low for 1 cycle during the stable count: the locked declaration is delayed by a full 8 additional cycles.
- Write START=0x4 while channel 0 is in WAIT: channel 2 follows channel 0, and busy stays high continuously throughout.
- Deassert reset_n mid-ASSERT: rst_out returns to 1111, pending clears, and CUR reads state code 0.
